// File: rtl/pc_fetch_pkg.sv
// rtl/pc_fetch_pkg.sv - shared types and default constants for the PC fetch controller
package pc_fetch_pkg;

    localparam int ADDR_W_DEF    = 32;
    localparam int RESET_PC_DEF  = 0;
    localparam int FETCH_TMO_DEF = 15;

    typedef enum logic [2:0] {
        BOOT,
        FETCH,
        ISSUE,
        EXEC,
        HALT
    } fetch_state_t;

endpackage

// File: rtl/pc_fetch_if.sv
// rtl/pc_fetch_if.sv - instruction memory request/ready bus
// master: req, addr out; ready, rdata in (fetch controller side)
// slave:  req, addr in;  ready, rdata out (instruction memory side)
interface pc_fetch_if
    import pc_fetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              ready;
    logic [31:0]       rdata;

    modport master (output req, output addr, input ready, input rdata);
    modport slave  (input req, input addr, output ready, output rdata);
endinterface

// File: rtl/pc_perf_counter.sv
// rtl/pc_perf_counter.sv - free-running retired-instruction counter, wraps at 2^32
// Ports: clk, rst (sync active-high), inc (count enable), cnt (current count)
module pc_perf_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    output logic [31:0] cnt
);
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 32'd1;
        end
    end
endmodule

// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - program counter register and fetch/issue/execute sequencer
// Ports: clk, rst (sync active-high); next_address, exec_valid, halt from execute/jump_unit;
//        stall freezes issue; imem (pc_fetch_if.master) fetch bus; pc to jump_unit PCin;
//        instr/instr_valid to decode; halted, fetch_err (sticky) status; retired_cnt.
// Build option: PERF_CNT_EN instantiates the retired-instruction counter, otherwise retired_cnt=0.
module pc_fetch_ctrl
    import pc_fetch_pkg::*;
#(
    parameter int                ADDR_W    = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(RESET_PC_DEF),
    parameter int                FETCH_TMO = FETCH_TMO_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] next_address,
    input  logic              exec_valid,
    input  logic              halt,
    input  logic              stall,
    pc_fetch_if.master        imem,
    output logic [ADDR_W-1:0] pc,
    output logic [31:0]       instr,
    output logic              instr_valid,
    output logic              halted,
    output logic              fetch_err,
    output logic [31:0]       retired_cnt
);
    localparam int               TMO_W   = $clog2(FETCH_TMO + 1);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(FETCH_TMO);

    fetch_state_t     state;
    logic [TMO_W-1:0] tmo_cnt;
    logic             req_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= BOOT;
            pc        <= RESET_PC;
            instr     <= '0;
            halted    <= 1'b0;
            fetch_err <= 1'b0;
            req_q     <= 1'b0;
            tmo_cnt   <= '0;
        end else begin
            case (state)
                BOOT: begin
                    state <= FETCH;
                    req_q <= 1'b1;
                end
                FETCH: begin
                    if (imem.ready) begin
                        instr   <= imem.rdata;
                        tmo_cnt <= '0;
                        req_q   <= 1'b0;
                        state   <= ISSUE;
                    end else if (tmo_cnt + 1'b1 == TMO_MAX) begin
                        // This cycle is the FETCH_TMO-th one without ready.
                        fetch_err <= 1'b1;
                        tmo_cnt   <= TMO_MAX;
                        req_q     <= 1'b0;
                        state     <= HALT;
                    end else if (tmo_cnt != TMO_MAX) begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ISSUE: begin
                    if (!stall) begin
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (exec_valid) begin
                        if (halt) begin
                            halted <= 1'b1;
                            state  <= HALT;
                        end else begin
                            pc    <= next_address;
                            req_q <= 1'b1;
                            state <= FETCH;
                        end
                    end
                end
                HALT: begin
                    req_q <= 1'b0;
                end
                default: begin
                    req_q <= 1'b0;
                    state <= HALT;
                end
            endcase
        end
    end

    assign imem.req  = req_q;
    assign imem.addr = pc;

    // The issue pulse must land in the same cycle stall drops, so it is
    // decoded from the registered state rather than registered itself.
    assign instr_valid = (state == ISSUE) && !stall;

`ifdef PERF_CNT_EN
    pc_perf_counter u_perf (
        .clk (clk),
        .rst (rst),
        .inc ((state == EXEC) && exec_valid),
        .cnt (retired_cnt)
    );
`else
    assign retired_cnt = '0;
`endif

endmodule
